// File: rtl/fetch_unit_if.sv
// Bus between a fetch_unit and its controller: execution control, branch request and PC/status outputs.
interface fetch_unit_if #(
    parameter int PC_W  = 8,
    parameter int CNT_W = 16
);
    logic             start;
    logic             stall;
    logic             branch_en;
    logic             branch_rel;
    logic [PC_W-1:0]  branch_target;
    logic             halt_req;
    logic [PC_W-1:0]  pc;
    logic             running;
    logic             done;
    logic [CNT_W-1:0] cycle_cnt;

    modport master (
        output start, stall, branch_en, branch_rel, branch_target, halt_req,
        input  pc, running, done, cycle_cnt
    );

    modport slave (
        input  start, stall, branch_en, branch_rel, branch_target, halt_req,
        output pc, running, done, cycle_cnt
    );
endinterface

// File: rtl/fetch_unit.sv
// Instruction fetch sequencer: IDLE/RUN/HALTED FSM driving a registered PC with branch support.
// Optional RUN cycle counter enabled by defining FETCH_CYCLE_CNT_EN.
module fetch_unit #(
    parameter int PC_W  = 8,
    parameter int CNT_W = 16
) (
    input  logic         clk,
    input  logic         reset,
    fetch_unit_if.slave  bus
);

    typedef enum logic [1:0] {
        ST_IDLE   = 2'b00,
        ST_RUN    = 2'b01,
        ST_HALTED = 2'b10
    } state_t;

    state_t          state_r;
    logic [PC_W-1:0] pc_r;
    logic            running_r;
    logic            done_r;
    logic [PC_W-1:0] next_pc_s;

    // A relative target is a two's-complement offset of PC width, so a plain modular add sign-extends it.
    function automatic logic [PC_W-1:0] branch_dest(
        input logic            rel,
        input logic [PC_W-1:0] pc_v,
        input logic [PC_W-1:0] tgt
    );
        logic [PC_W-1:0] dest;
        if (rel) begin
            dest = pc_v + tgt;
        end else begin
            dest = tgt;
        end
        return dest;
    endfunction

    // Next PC while running: halt > stall > branch > increment.
    always_comb begin
        next_pc_s = pc_r;
        if (bus.halt_req) begin
            next_pc_s = pc_r;
        end else if (bus.stall) begin
            next_pc_s = pc_r;
        end else if (bus.branch_en) begin
            next_pc_s = branch_dest(bus.branch_rel, pc_r, bus.branch_target);
        end else begin
            next_pc_s = pc_r + PC_W'(1);
        end
    end

    // Control FSM with registered PC and status flags.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_r   <= ST_IDLE;
            pc_r      <= {PC_W{1'b0}};
            running_r <= 1'b0;
            done_r    <= 1'b0;
        end else begin
            case (state_r)
                ST_IDLE: begin
                    if (bus.start) begin
                        state_r   <= ST_RUN;
                        pc_r      <= {PC_W{1'b0}};
                        running_r <= 1'b1;
                        done_r    <= 1'b0;
                    end else begin
                        state_r   <= ST_IDLE;
                        pc_r      <= {PC_W{1'b0}};
                        running_r <= 1'b0;
                        done_r    <= 1'b0;
                    end
                end
                ST_RUN: begin
                    pc_r <= next_pc_s;
                    if (bus.halt_req) begin
                        state_r   <= ST_HALTED;
                        running_r <= 1'b0;
                        done_r    <= 1'b1;
                    end else begin
                        state_r   <= ST_RUN;
                        running_r <= 1'b1;
                        done_r    <= 1'b0;
                    end
                end
                ST_HALTED: begin
                    if (bus.start) begin
                        state_r   <= ST_RUN;
                        pc_r      <= {PC_W{1'b0}};
                        running_r <= 1'b1;
                        done_r    <= 1'b0;
                    end else begin
                        state_r   <= ST_HALTED;
                        pc_r      <= pc_r;
                        running_r <= 1'b0;
                        done_r    <= 1'b1;
                    end
                end
                default: begin
                    state_r   <= ST_IDLE;
                    pc_r      <= {PC_W{1'b0}};
                    running_r <= 1'b0;
                    done_r    <= 1'b0;
                end
            endcase
        end
    end

    assign bus.pc      = pc_r;
    assign bus.running = running_r;
    assign bus.done    = done_r;

`ifdef FETCH_CYCLE_CNT_EN
    logic [CNT_W-1:0] cnt_r;
    logic             enter_run_s;

    assign enter_run_s = ((state_r == ST_IDLE) || (state_r == ST_HALTED)) && bus.start;

    // Saturating count of edges spent in RUN; cleared on the edge that enters RUN.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cnt_r <= {CNT_W{1'b0}};
        end else if (enter_run_s) begin
            cnt_r <= {CNT_W{1'b0}};
        end else if ((state_r == ST_RUN) && (cnt_r != {CNT_W{1'b1}})) begin
            cnt_r <= cnt_r + CNT_W'(1);
        end else begin
            cnt_r <= cnt_r;
        end
    end

    assign bus.cycle_cnt = cnt_r;
`else
    assign bus.cycle_cnt = {CNT_W{1'b0}};
`endif

endmodule

// File: tb/tb_fetch_unit.sv
// Self-checking bench for fetch_unit: vector table through a scoreboard, plus reset and narrow-width corner sequences.
module tb_fetch_unit;

    logic clk = 1'b0;
    logic reset;
    logic reset2;

    always #5 clk = ~clk;

    fetch_unit_if #(.PC_W(8), .CNT_W(16)) bus ();
    fetch_unit_if #(.PC_W(4), .CNT_W(3))  bus2 ();

    fetch_unit #(.PC_W(8), .CNT_W(16)) dut  (.clk(clk), .reset(reset),  .bus(bus));
    fetch_unit #(.PC_W(4), .CNT_W(3))  dut2 (.clk(clk), .reset(reset2), .bus(bus2));

    typedef struct {
        logic        start;
        logic        stall;
        logic        br_en;
        logic        br_rel;
        logic [7:0]  tgt;
        logic        halt;
        logic [7:0]  pc;
        logic        run;
        logic        done;
        logic [15:0] cnt;
    } vec_t;

    typedef struct {
        logic [7:0]  pc;
        logic        run;
        logic        done;
        logic [15:0] cnt;
        int          id;
    } exp_t;

    int   checks = 0;
    int   errors = 0;
    exp_t sb[$];
    vec_t vecs[33];

    function automatic vec_t mk(logic st, logic sl, logic be, logic br, logic [7:0] tg, logic hl,
                                logic [7:0] p, logic r, logic d, logic [15:0] c);
        vec_t v;
        v.start = st; v.stall = sl; v.br_en = be; v.br_rel = br; v.tgt = tg; v.halt = hl;
        v.pc = p; v.run = r; v.done = d; v.cnt = c;
        return v;
    endfunction

    function automatic logic [15:0] cnt_exp(logic [15:0] c);
`ifdef FETCH_CYCLE_CNT_EN
        return c;
`else
        return 16'd0 & c;
`endif
    endfunction

    task automatic check_out(string name, logic [7:0] p, logic r, logic d, logic [15:0] c);
        checks++;
        if (bus.pc !== p || bus.running !== r || bus.done !== d || bus.cycle_cnt !== cnt_exp(c)) begin
            errors++;
            $display("FAIL %s: got pc=%0d running=%0b done=%0b cnt=%0d, expected pc=%0d running=%0b done=%0b cnt=%0d",
                     name, bus.pc, bus.running, bus.done, bus.cycle_cnt, p, r, d, cnt_exp(c));
        end
    endtask

    task automatic drive_idle();
        bus.start = 1'b0; bus.stall = 1'b0; bus.branch_en = 1'b0;
        bus.branch_rel = 1'b0; bus.branch_target = 8'd0; bus.halt_req = 1'b0;
    endtask

    task automatic apply(vec_t v, int id);
        exp_t e;
        @(negedge clk);
        bus.start = v.start; bus.stall = v.stall; bus.branch_en = v.br_en;
        bus.branch_rel = v.br_rel; bus.branch_target = v.tgt; bus.halt_req = v.halt;
        e.pc = v.pc; e.run = v.run; e.done = v.done; e.cnt = v.cnt; e.id = id;
        sb.push_back(e);
        @(posedge clk);
        #1;
        e = sb.pop_front();
        check_out($sformatf("vec%0d", e.id), e.pc, e.run, e.done, e.cnt);
    endtask

    initial begin
        reset = 1'b1;
        reset2 = 1'b1;
        drive_idle();
        bus2.start = 1'b0; bus2.stall = 1'b0; bus2.branch_en = 1'b0;
        bus2.branch_rel = 1'b0; bus2.branch_target = 4'd0; bus2.halt_req = 1'b0;

        vecs[0] = mk(0,0,0,0,8'd0,0,    8'd0,  0,0,16'd0);
        vecs[1] = mk(1,0,0,0,8'd0,0,    8'd0,  1,0,16'd0);
        for (int k = 1; k <= 10; k++)
            vecs[1+k] = mk(0,0,0,0,8'd0,0, 8'(k), 1,0,16'(k));
        vecs[12] = mk(0,0,1,0,8'd87,0,  8'd87, 1,0,16'd11);
        vecs[13] = mk(0,0,1,0,8'd10,0,  8'd10, 1,0,16'd12);
        vecs[14] = mk(0,0,1,1,8'hFE,0,  8'd8,  1,0,16'd13);
        vecs[15] = mk(1,0,0,0,8'd0,0,   8'd9,  1,0,16'd14);
        vecs[16] = mk(0,0,1,0,8'd254,0, 8'd254,1,0,16'd15);
        vecs[17] = mk(0,0,1,1,8'd3,0,   8'd1,  1,0,16'd16);
        vecs[18] = mk(0,0,1,0,8'd255,0, 8'd255,1,0,16'd17);
        vecs[19] = mk(0,0,0,0,8'd0,0,   8'd0,  1,0,16'd18);
        vecs[20] = mk(0,0,1,0,8'd20,0,  8'd20, 1,0,16'd19);
        vecs[21] = mk(0,1,1,0,8'd99,0,  8'd20, 1,0,16'd20);
        vecs[22] = mk(0,1,1,1,8'd99,0,  8'd20, 1,0,16'd21);
        vecs[23] = mk(0,0,0,0,8'd0,0,   8'd21, 1,0,16'd22);
        vecs[24] = mk(0,1,0,0,8'd0,0,   8'd21, 1,0,16'd23);
        vecs[25] = mk(0,0,1,0,8'd57,0,  8'd57, 1,0,16'd24);
        vecs[26] = mk(0,1,1,0,8'd3,1,   8'd57, 0,1,16'd25);
        vecs[27] = mk(0,0,1,0,8'd9,0,   8'd57, 0,1,16'd25);
        vecs[28] = mk(1,0,0,0,8'd0,0,   8'd0,  1,0,16'd0);
        vecs[29] = mk(0,0,0,0,8'd0,0,   8'd1,  1,0,16'd1);
        vecs[30] = mk(0,0,0,0,8'd0,1,   8'd1,  0,1,16'd2);
        vecs[31] = mk(1,0,0,0,8'd0,1,   8'd0,  1,0,16'd0);
        vecs[32] = mk(0,0,0,0,8'd0,0,   8'd1,  1,0,16'd1);

        @(posedge clk);
        #2;
        check_out("reset_state", 8'd0, 1'b0, 1'b0, 16'd0);
        @(negedge clk);
        reset = 1'b0;

        for (int i = 0; i < 33; i++)
            apply(vecs[i], i);

        // Asynchronous reset mid-RUN, with start held during reset.
        apply(mk(0,0,0,0,8'd0,0, 8'd2,1,0,16'd2), 40);
        @(negedge clk);
        #2;
        reset = 1'b1;
        #1;
        check_out("async_reset_run", 8'd0, 1'b0, 1'b0, 16'd0);
        bus.start = 1'b1;
        @(posedge clk);
        #1;
        check_out("start_in_reset_a", 8'd0, 1'b0, 1'b0, 16'd0);
        @(posedge clk);
        #1;
        check_out("start_in_reset_b", 8'd0, 1'b0, 1'b0, 16'd0);
        @(negedge clk);
        reset = 1'b0;
        drive_idle();
        apply(mk(0,0,0,0,8'd0,0, 8'd0,0,0,16'd0), 41);
        apply(mk(0,0,0,0,8'd0,0, 8'd0,0,0,16'd0), 42);
        apply(mk(1,0,0,0,8'd0,0, 8'd0,1,0,16'd0), 43);
        apply(mk(0,0,0,0,8'd0,0, 8'd1,1,0,16'd1), 44);
        apply(mk(0,0,1,0,8'd33,0, 8'd33,1,0,16'd2), 45);

        // Reset while HALTED.
        apply(mk(0,0,0,0,8'd0,1, 8'd33,0,1,16'd3), 46);
        @(negedge clk);
        #2;
        reset = 1'b1;
        #1;
        check_out("async_reset_halted", 8'd0, 1'b0, 1'b0, 16'd0);
        @(negedge clk);
        reset = 1'b0;
        drive_idle();
        apply(mk(0,0,0,0,8'd0,0, 8'd0,0,0,16'd0), 47);
        apply(mk(1,0,0,0,8'd0,0, 8'd0,1,0,16'd0), 48);

        // Narrow instance: PC wrap at 15 and counter saturation at 7.
        @(negedge clk);
        reset2 = 1'b0;
        bus2.start = 1'b1;
        @(posedge clk);
        #1;
        checks++;
        if (bus2.pc !== 4'd0 || bus2.running !== 1'b1 || bus2.cycle_cnt !== 3'd0) begin
            errors++;
            $display("FAIL narrow_start: got pc=%0d running=%0b cnt=%0d, expected pc=0 running=1 cnt=0",
                     bus2.pc, bus2.running, bus2.cycle_cnt);
        end
        @(negedge clk);
        bus2.start = 1'b0;
        for (int k = 1; k <= 20; k++) begin
            logic [3:0] ep;
            logic [2:0] ec;
            ep = 4'(k);
`ifdef FETCH_CYCLE_CNT_EN
            ec = (k > 7) ? 3'd7 : 3'(k);
`else
            ec = 3'd0;
`endif
            @(posedge clk);
            #1;
            checks++;
            if (bus2.pc !== ep || bus2.running !== 1'b1 || bus2.cycle_cnt !== ec) begin
                errors++;
                $display("FAIL narrow_step%0d: got pc=%0d running=%0b cnt=%0d, expected pc=%0d running=1 cnt=%0d",
                         k, bus2.pc, bus2.running, bus2.cycle_cnt, ep, ec);
            end
        end

        if (sb.size() != 0) begin
            errors++;
            $display("FAIL scoreboard_drain: got %0d leftover entries, expected 0", sb.size());
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
